// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures the memory word into the IF/ID register.
// Optional macro FETCH_ALIGN_CHK_EN forces word-aligned redirect targets and raises a sticky misalign flag.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [31:0]      pc_addr_o,
  input  logic [31:0]      instr_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  input  logic             halt_i,
  input  logic             id_ready_i,
  output logic             id_valid_o,
  output logic [31:0]      id_instr_o,
  output logic [31:0]      id_pc_o,
  output logic [31:0]      id_pc4_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic             misalign_o
);

  logic [31:0] pc;
  logic [31:0] target;
  logic        adv;
  logic        xfer;

  assign pc_addr_o = pc;
  assign adv       = !id_valid_o || id_ready_i;
  assign xfer      = id_valid_o && id_ready_i;

`ifdef FETCH_ALIGN_CHK_EN
  assign target = {redirect_pc_i[31:2], 2'b00};

  // Sticky until reset: any redirect with low address bits set is recorded.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      misalign_o <= 1'b0;
    else if (redirect_i && (redirect_pc_i[1:0] != 2'b00))
      misalign_o <= 1'b1;
  end
`else
  assign target     = redirect_pc_i;
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc          <= RESET_PC;
      id_valid_o  <= 1'b0;
      id_instr_o  <= 32'h0;
      id_pc_o     <= 32'h0;
      id_pc4_o    <= 32'h0;
      fetch_cnt_o <= '0;
    end else begin
      // A transfer to decode counts even when a redirect squashes the incoming word.
      if (xfer)
        fetch_cnt_o <= fetch_cnt_o + CNT_W'(1);

      if (redirect_i) begin
        pc         <= target;
        id_valid_o <= 1'b0;
        id_instr_o <= 32'h0;
      end else if (halt_i) begin
        if (adv)
          id_valid_o <= 1'b0;
      end else if (adv) begin
        id_instr_o <= instr_i;
        id_pc_o    <= pc;
        id_pc4_o   <= pc + 32'd4;
        id_valid_o <= 1'b1;
        pc         <= pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, wrap-around instance, then random traffic vs a rule model.
module tb_if_fetch_stage;

`ifdef FETCH_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, redirect, halt, ready;
  logic [31:0] redirect_pc;
  logic [31:0] pc_addr, instr, id_instr, id_pc, id_pc4;
  logic        id_valid, misalign;
  logic [15:0] cnt;

  logic        w_rst, w_ready;
  logic [31:0] w_pc_addr, w_instr, w_id_instr, w_id_pc, w_id_pc4;
  logic        w_id_valid, w_misalign;
  logic [15:0] w_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory: word n holds n + 0x100, returned combinationally.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a >> 2) + 32'h100;
  endfunction

  assign instr   = mem(pc_addr);
  assign w_instr = mem(w_pc_addr);

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .pc_addr_o(pc_addr), .instr_i(instr),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .halt_i(halt),
    .id_ready_i(ready), .id_valid_o(id_valid), .id_instr_o(id_instr),
    .id_pc_o(id_pc), .id_pc4_o(id_pc4), .fetch_cnt_o(cnt), .misalign_o(misalign)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(16)) dut_wrap (
    .clk_i(clk), .rst_i(w_rst), .pc_addr_o(w_pc_addr), .instr_i(w_instr),
    .redirect_i(1'b0), .redirect_pc_i(32'h0), .halt_i(1'b0),
    .id_ready_i(w_ready), .id_valid_o(w_id_valid), .id_instr_o(w_id_instr),
    .id_pc_o(w_id_pc), .id_pc4_o(w_id_pc4), .fetch_cnt_o(w_cnt), .misalign_o(w_misalign)
  );

  typedef struct {
    logic        rst, redirect;
    logic [31:0] rpc;
    logic        halt, ready;
    logic        valid;
    logic [31:0] idpc, pc4, ins, addr;
    logic [15:0] cnt;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic r, input logic rd, input logic [31:0] rp, input logic h,
                      input logic rdy, input logic v, input logic [31:0] ip, input logic [31:0] p4,
                      input logic [31:0] in, input logic [31:0] ad, input logic [15:0] c,
                      input logic m);
    vec_t t;
    t = '{r, rd, rp, h, rdy, v, ip, p4, in, ad, c, m};
    vecs.push_back(t);
  endtask

  task automatic chk(input string what, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d actual=%h expected=%h", what, idx, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int idx, input logic v, input logic [31:0] ip,
                             input logic [31:0] p4, input logic [31:0] in, input logic [31:0] ad,
                             input logic [15:0] c, input logic m);
    chk({tag, ".id_valid"}, idx, {31'b0, id_valid}, {31'b0, v});
    chk({tag, ".id_pc"}, idx, id_pc, ip);
    chk({tag, ".id_pc4"}, idx, id_pc4, p4);
    chk({tag, ".id_instr"}, idx, id_instr, in);
    chk({tag, ".pc_addr"}, idx, pc_addr, ad);
    chk({tag, ".fetch_cnt"}, idx, {16'b0, cnt}, {16'b0, c});
    chk({tag, ".misalign"}, idx, {31'b0, misalign}, {31'b0, m});
  endtask

  task automatic applyStimulus(input logic r, input logic rd, input logic [31:0] rp,
                               input logic h, input logic rdy);
    rst = r; redirect = rd; redirect_pc = rp; halt = h; ready = rdy;
  endtask

  // Reference model state, advanced from the priority rules once per clock.
  logic [31:0] m_pc, m_idpc, m_pc4, m_ins;
  logic        m_valid, m_mis;
  logic [15:0] m_cnt;

  task automatic model_step(input logic r, input logic rd, input logic [31:0] rp,
                            input logic h, input logic rdy);
    logic [31:0] fetched;
    fetched = mem(m_pc);
    if (r) begin
      m_pc = 32'h0; m_valid = 0; m_ins = 0; m_idpc = 0; m_pc4 = 0; m_cnt = 0; m_mis = 0;
      return;
    end
    if (m_valid && rdy) m_cnt = m_cnt + 16'd1;
    if (rd) begin
      if (ALIGN && (rp % 4 != 0)) begin
        m_pc  = rp - (rp % 4);
        m_mis = 1;
      end else begin
        m_pc = rp;
      end
      m_valid = 0;
      m_ins   = 0;
    end else if (h) begin
      if (!m_valid || rdy) m_valid = 0;
    end else if (!m_valid || rdy) begin
      m_ins = fetched; m_idpc = m_pc; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
    end
  endtask

  initial begin
    w_rst = 1'b1;
    w_ready = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);

    //   rst rd rpc        h  rdy  valid idpc      pc4       instr     addr      cnt mis
    addv(1, 0, 32'h0,    0, 1,   0, 32'h0,   32'h0,   32'h0,   32'h0,   0, 0);
    addv(0, 0, 32'h0,    0, 1,   1, 32'h0,   32'h4,   32'h100, 32'h4,   0, 0);
    addv(0, 0, 32'h0,    0, 1,   1, 32'h4,   32'h8,   32'h101, 32'h8,   1, 0);
    addv(0, 0, 32'h0,    0, 1,   1, 32'h8,   32'hC,   32'h102, 32'hC,   2, 0);
    addv(0, 0, 32'h0,    0, 0,   1, 32'h8,   32'hC,   32'h102, 32'hC,   2, 0);
    addv(0, 0, 32'h0,    0, 0,   1, 32'h8,   32'hC,   32'h102, 32'hC,   2, 0);
    addv(0, 0, 32'h0,    0, 0,   1, 32'h8,   32'hC,   32'h102, 32'hC,   2, 0);
    addv(0, 0, 32'h0,    0, 1,   1, 32'hC,   32'h10,  32'h103, 32'h10,  3, 0);
    addv(0, 0, 32'h0,    0, 1,   1, 32'h10,  32'h14,  32'h104, 32'h14,  4, 0);
    addv(0, 0, 32'h0,    0, 0,   1, 32'h10,  32'h14,  32'h104, 32'h14,  4, 0);
    addv(0, 1, 32'h40,   0, 0,   0, 32'h10,  32'h14,  32'h0,   32'h40,  4, 0);
    addv(0, 0, 32'h0,    0, 1,   1, 32'h40,  32'h44,  32'h110, 32'h44,  4, 0);
    addv(0, 0, 32'h0,    1, 1,   0, 32'h40,  32'h44,  32'h110, 32'h44,  5, 0);
    addv(0, 0, 32'h0,    1, 1,   0, 32'h40,  32'h44,  32'h110, 32'h44,  5, 0);
    addv(0, 0, 32'h0,    0, 1,   1, 32'h44,  32'h48,  32'h111, 32'h48,  5, 0);
    addv(0, 1, 32'h80,   0, 1,   0, 32'h44,  32'h48,  32'h0,   32'h80,  6, 0);
    addv(0, 1, 32'h100,  1, 1,   0, 32'h44,  32'h48,  32'h0,   32'h100, 6, 0);
    addv(0, 0, 32'h0,    1, 1,   0, 32'h44,  32'h48,  32'h0,   32'h100, 6, 0);
    addv(0, 0, 32'h0,    0, 1,   1, 32'h100, 32'h104, 32'h140, 32'h104, 6, 0);
    addv(1, 0, 32'h0,    0, 1,   0, 32'h0,   32'h0,   32'h0,   32'h0,   0, 0);
    addv(0, 1, 32'h20,   0, 1,   0, 32'h0,   32'h0,   32'h0,   32'h20,  0, 0);
    addv(0, 0, 32'h0,    0, 1,   1, 32'h20,  32'h24,  32'h108, 32'h24,  0, 0);
    addv(0, 1, 32'h46,   0, 1,   0, 32'h20,  32'h24,  32'h0,   ALIGN ? 32'h44 : 32'h46, 1, ALIGN);
    addv(0, 1, 32'h80,   0, 1,   0, 32'h20,  32'h24,  32'h0,   32'h80,  1, ALIGN);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].redirect, vecs[i].rpc, vecs[i].halt, vecs[i].ready);
      @(posedge clk); #1;
      checkOutput("vec", i, vecs[i].valid, vecs[i].idpc, vecs[i].pc4, vecs[i].ins,
                  vecs[i].addr, vecs[i].cnt, vecs[i].mis);
    end

    // PC wrap-around with RESET_PC at the top word of the address space.
    chk("wrap.reset_addr", 0, w_pc_addr, 32'hFFFF_FFFC);
    chk("wrap.reset_valid", 0, {31'b0, w_id_valid}, 32'h0);
    w_rst = 1'b0;
    @(posedge clk); #1;
    chk("wrap.valid", 1, {31'b0, w_id_valid}, 32'h1);
    chk("wrap.id_pc", 1, w_id_pc, 32'hFFFF_FFFC);
    chk("wrap.id_pc4", 1, w_id_pc4, 32'h0);
    chk("wrap.id_instr", 1, w_id_instr, 32'h4000_00FF);
    chk("wrap.pc_addr", 1, w_pc_addr, 32'h0);
    @(posedge clk); #1;
    chk("wrap.id_pc", 2, w_id_pc, 32'h0);
    chk("wrap.id_pc4", 2, w_id_pc4, 32'h4);
    chk("wrap.id_instr", 2, w_id_instr, 32'h100);
    chk("wrap.cnt", 2, {16'b0, w_cnt}, 32'h1);
    w_rst = 1'b1;
    @(posedge clk); #1;
    chk("wrap.rst_addr", 3, w_pc_addr, 32'hFFFF_FFFC);
    chk("wrap.rst_valid", 3, {31'b0, w_id_valid}, 32'h0);
    chk("wrap.rst_cnt", 3, {16'b0, w_cnt}, 32'h0);
    chk("wrap.misalign", 3, {31'b0, w_misalign}, 32'h0);

    // Random traffic against the rule model, starting from a reset.
    applyStimulus(1, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput("rnd", 0, m_valid, m_idpc, m_pc4, m_ins, m_pc, m_cnt, m_mis);
    for (int i = 1; i <= 600; i++) begin
      logic        r, rd, h, rdy;
      logic [31:0] rp;
      r   = ($urandom_range(0, 59) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      h   = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0: rp = $urandom() & 32'hFFFF_FFFC;
        1: rp = $urandom();
        2: rp = 32'hFFFF_FFF8;
        default: rp = $urandom_range(0, 255);
      endcase
      applyStimulus(r, rd, rp, h, rdy);
      model_step(r, rd, rp, h, rdy);
      @(posedge clk); #1;
      checkOutput("rnd", i, m_valid, m_idpc, m_pc4, m_ins, m_pc, m_cnt, m_mis);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
